// File: rtl/udiv8_seq.sv
// Iterative radix-2 restoring unsigned divider with start/busy/done handshake.
// Optional: define UDIV_EARLY_EXIT_EN to finish in one cycle when dividend < divisor.
`timescale 1ns/1ps
module udiv8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:WIDTH-1] dividend,
  input  logic [0:WIDTH-1] divisor,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] quotient,
  output logic [0:WIDTH-1] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             accept;
  logic             fast;

  always_comb begin
    shifted    = {rem[WIDTH-1:0], quo_w[WIDTH-1]};
    ge         = (shifted >= {1'b0, dvs});
    rem_nx     = ge ? (shifted - {1'b0, dvs}) : shifted;
    quo_nx     = {quo_w[WIDTH-2:0], ge};
    accept     = start && ((state == IDLE) || (state == DONE));
    fast       = (divisor == '0);
`ifdef UDIV_EARLY_EXIT_EN
    fast       = fast || (dividend < divisor);
`endif
    busy       = (state == CALC);
    done       = (state == DONE);
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fast ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = accept ? (fast ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quo_w       <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        quo_w <= dividend;
        dvs   <= divisor;
        rem   <= '0;
        cnt   <= CW'(WIDTH - 1);
        // Short-circuit cases commit their result on the accepting edge itself.
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
`ifdef UDIV_EARLY_EXIT_EN
        else if (dividend < divisor) begin
          quotient    <= '0;
          remainder   <= dividend;
          div_by_zero <= 1'b0;
        end
`endif
      end else if (state == CALC) begin
        quo_w <= quo_nx;
        rem   <= rem_nx;
        cnt   <= cnt - 1'b1;
        if (cnt == '0) begin
          quotient    <= quo_nx;
          remainder   <= rem_nx[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_udiv8_seq.sv
// Self-checking bench for udiv8_seq: directed scenarios plus a random sweep
// against an arithmetic reference (/ and %), latency and handshake checks.
`timescale 1ns/1ps
module tb_udiv8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef UDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  udiv8_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edges after the accepting edge until done is visible (0 = done in the very next cycle).
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return 0;
    if (EARLY && (a < b)) return 0;
    return 8;
  endfunction

  // Drive one request and wait (bounded) for done; performs no comparisons itself.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, bcnt, ndone;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    idle_cycle();
    run_op(8'hFF, 8'h10, lat, bcnt);
    idle_cycle();
    start = 1'b1; dividend = 8'h06; divisor = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder} !== 18'd0) begin
      failures++;
      $display("FAIL reset_mid_calc: busy=%b done=%b q=%h r=%h, required 0 0 00 00",
               busy, done, quotient, remainder);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_abort_no_done: saw %0d done cycles, required 0", ndone);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_op(8'h06, 8'h03, lat, bcnt);
    checks++;
    if (lat != 8 || bcnt != 8) begin
      failures++;
      $display("FAIL basic_latency: lat=%0d busy_cycles=%0d, required 8 8", lat, bcnt);
    end
    checks++;
    if (quotient !== 8'h02 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: q=%h r=%h dbz=%b, required 02 00 0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || quotient !== 8'h02) begin
      failures++;
      $display("FAIL done_one_cycle: done=%b q=%h, required 0 02", done, quotient);
    end
  endtask

  task automatic test_limits();
    int lat, bcnt;
    run_op(8'hFF, 8'h10, lat, bcnt);
    checks++;
    if (quotient !== 8'h0F || remainder !== 8'h0F || lat != 8) begin
      failures++;
      $display("FAIL limit_ff_10: q=%h r=%h lat=%0d, required 0f 0f 8", quotient, remainder, lat);
    end
    idle_cycle();
    run_op(8'hFF, 8'h01, lat, bcnt);
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'h00 || lat != 8) begin
      failures++;
      $display("FAIL limit_ff_01: q=%h r=%h lat=%0d, required ff 00 8", quotient, remainder, lat);
    end
    idle_cycle();
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_op(8'h5A, 8'h00, lat, bcnt);
    checks++;
    if (lat != 0 || bcnt != 0) begin
      failures++;
      $display("FAIL dz_latency: lat=%0d busy_cycles=%0d, required 0 0", lat, bcnt);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'h5A || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result: q=%h r=%h dbz=%b, required ff 5a 1", quotient, remainder, div_by_zero);
    end
    idle_cycle();
    run_op(8'h09, 8'h02, lat, bcnt);
    checks++;
    if (quotient !== 8'h04 || remainder !== 8'h01 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear: q=%h r=%h dbz=%b, required 04 01 0", quotient, remainder, div_by_zero);
    end
    idle_cycle();
  endtask

  // Expects the previous committed result to be 9/2 (q=04, r=01).
  task automatic test_handshake();
    int lat, bcnt, c1, c2, bad_hold;
    start = 1'b1; dividend = 8'h64; divisor = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bad_hold = 0;
    while (!done && lat < 30) begin
      if (quotient !== 8'h04 || remainder !== 8'h01) bad_hold++;
      if (lat == 3) begin
        start = 1'b1; dividend = 8'h07; divisor = 8'h02;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if (bad_hold != 0) begin
      failures++;
      $display("FAIL hold_during_calc: %0d cycles with changed outputs, required 0", bad_hold);
    end
    checks++;
    if (lat != 8 || quotient !== 8'h0E || remainder !== 8'h02) begin
      failures++;
      $display("FAIL start_while_busy: lat=%0d q=%h r=%h, required 8 0e 02", lat, quotient, remainder);
    end
    c1 = cyc;
    run_op(8'h09, 8'h02, lat, bcnt);
    c2 = cyc;
    checks++;
    if (c2 - c1 != 9 || quotient !== 8'h04 || remainder !== 8'h01) begin
      failures++;
      $display("FAIL back_to_back: done spacing=%0d q=%h r=%h, required 9 04 01", c2 - c1, quotient, remainder);
    end
    idle_cycle();
  endtask

  task automatic test_early_exit();
    int lat, bcnt;
    run_op(8'h03, 8'h07, lat, bcnt);
    checks++;
    if (quotient !== 8'h00 || remainder !== 8'h03 || lat != exp_lat(8'h03, 8'h07)) begin
      failures++;
      $display("FAIL early_exit: q=%h r=%h lat=%0d, required 00 03 %0d",
               quotient, remainder, lat, exp_lat(8'h03, 8'h07));
    end
    idle_cycle();
  endtask

  task automatic test_random_sweep();
    int lat, bcnt, elat;
    logic [7:0] a, b, eq, er;
    logic [15:0] prod;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = (i % 16 == 0) ? 8'h00 : ((i % 3 == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom));
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      elat = exp_lat(a, b);
      run_op(a, b, lat, bcnt);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== (b == 0) ||
          lat != elat || bcnt != ((elat == 0) ? 0 : 8)) begin
        failures++;
        $display("FAIL rand_%0d %h/%h: q=%h r=%h dbz=%b lat=%0d busy=%0d, required %h %h %b %0d %0d",
                 i, a, b, quotient, remainder, div_by_zero, lat, bcnt,
                 eq, er, (b == 0), elat, (elat == 0) ? 0 : 8);
      end
      if (b != 0) begin
        prod = 16'(quotient) * 16'(b) + 16'(remainder);
        checks++;
        if (prod !== {8'h00, a} || remainder >= b) begin
          failures++;
          $display("FAIL rand_invariant_%0d: q*d+r=%h r=%h, required %h with r<%h", i, prod, remainder, a, b);
        end
      end
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_div_zero();
    test_handshake();
    test_early_exit();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
